// File: rtl/picoblaze_io_pkg.sv
// Port address map and interrupt FSM encoding shared by the PicoBlaze I/O hub.
package picoblaze_io_pkg;

    localparam logic [7:0] ADDR_IN_BASE  = 8'h00;
    localparam logic [7:0] ADDR_PENDING  = 8'h10;
    localparam logic [7:0] ADDR_MASK     = 8'h11;
    localparam logic [7:0] ADDR_CLEAR    = 8'h12;
    localparam logic [7:0] ADDR_OVERRUN  = 8'h13;
    localparam logic [7:0] ADDR_OUT_BASE = 8'h20;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_SERVICE
    } irq_state_t;

endpackage

// File: rtl/picoblaze_irq_ctrl.sv
// Interrupt edge capture, PENDING/MASK/OVERRUN registers and request handshake FSM.
//
//   state       | meaning
//   IRQ_IDLE    | no request outstanding
//   IRQ_REQ     | interrupt asserted, waiting for interrupt_ack
//   IRQ_SERVICE | acknowledged, handler running until a CLEAR write
module picoblaze_irq_ctrl
    import picoblaze_io_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               mask_wr,
    input  logic               clr_wr,
    input  logic               ovr_wr,
    input  logic [NUM_IRQ-1:0] wr_data,
    input  logic               interrupt_ack,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] overrun,
    output logic               interrupt
);

    irq_state_t         state, state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] edge_det;
    logic               armed;
    logic               active;

    // irq_q holds zero straight out of reset, so the first cycle is not trusted for edges
    assign edge_det = armed ? (irq_src & ~irq_q) : '0;
    assign active   = |(pending & mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            armed   <= 1'b0;
            pending <= '0;
            mask    <= '0;
            overrun <= '0;
            state   <= IRQ_IDLE;
        end else begin
            irq_q   <= irq_src;
            armed   <= 1'b1;
            pending <= (clr_wr ? (pending & ~wr_data) : pending) | edge_det;
            overrun <= (ovr_wr ? '0 : overrun) | (edge_det & pending);
            if (mask_wr) begin
                mask <= wr_data;
            end
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_IDLE: begin
                if (active) state_nxt = IRQ_REQ;
            end
            IRQ_REQ: begin
                if (interrupt_ack) state_nxt = IRQ_SERVICE;
                else if (!active)  state_nxt = IRQ_IDLE;
            end
            IRQ_SERVICE: begin
                if (clr_wr) state_nxt = IRQ_IDLE;
            end
            default: state_nxt = IRQ_IDLE;
        endcase
    end

    assign interrupt = (state == IRQ_REQ);

endmodule

// File: rtl/picoblaze_io_hub.sv
// PicoBlaze port-mapped I/O hub: input ports, output registers and an interrupt controller.
module picoblaze_io_hub
    import picoblaze_io_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int NUM_IRQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    input  logic [7:0]           out_port,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [NUM_IN*8-1:0]  in_data,
    output logic [NUM_IN-1:0]    in_rd_pulse,
    output logic [NUM_OUT*8-1:0] out_data,
    output logic [NUM_OUT-1:0]   out_wr_pulse,
    input  logic [NUM_IRQ-1:0]   irq_src
);

    logic               wr_mask, wr_clear, wr_overrun;
    logic [NUM_IRQ-1:0] pending, mask, overrun;
    logic [7:0]         rd_data;

    assign wr_mask    = write_strobe && (port_id == ADDR_MASK);
    assign wr_clear   = write_strobe && (port_id == ADDR_CLEAR);
    assign wr_overrun = write_strobe && (port_id == ADDR_OVERRUN);

    picoblaze_irq_ctrl #(
        .NUM_IRQ(NUM_IRQ)
    ) u_irq_ctrl (
        .clk          (clk),
        .reset        (reset),
        .irq_src      (irq_src),
        .mask_wr      (wr_mask),
        .clr_wr       (wr_clear),
        .ovr_wr       (wr_overrun),
        .wr_data      (out_port[NUM_IRQ-1:0]),
        .interrupt_ack(interrupt_ack),
        .pending      (pending),
        .mask         (mask),
        .overrun      (overrun),
        .interrupt    (interrupt)
    );

    // Anything not matched below (including the write-only CLEAR) reads as zero
    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            if (port_id == ADDR_IN_BASE + 8'(k)) rd_data = in_data[8*k +: 8];
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (port_id == ADDR_OUT_BASE + 8'(k)) rd_data = out_data[8*k +: 8];
        end
        if (port_id == ADDR_PENDING) rd_data[NUM_IRQ-1:0] = pending;
        if (port_id == ADDR_MASK)    rd_data[NUM_IRQ-1:0] = mask;
        if (port_id == ADDR_OVERRUN) rd_data[NUM_IRQ-1:0] = overrun;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_port      <= 8'h00;
            in_rd_pulse  <= '0;
            out_data     <= '0;
            out_wr_pulse <= '0;
        end else begin
            in_port <= rd_data;
            for (int k = 0; k < NUM_IN; k++) begin
                in_rd_pulse[k] <= read_strobe && (port_id == ADDR_IN_BASE + 8'(k));
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                out_wr_pulse[k] <= write_strobe && (port_id == ADDR_OUT_BASE + 8'(k));
                if (write_strobe && (port_id == ADDR_OUT_BASE + 8'(k))) begin
                    out_data[8*k +: 8] <= out_port;
                end
            end
        end
    end

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Bench for picoblaze_io_hub: cycle-level reference model plus directed scenarios with literal expectations.
module tb_picoblaze_io_hub;

    localparam int NUM_IN  = 4;
    localparam int NUM_OUT = 4;
    localparam int NUM_IRQ = 4;
    localparam int ALL_IRQ = (1 << NUM_IRQ) - 1;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_SERVICE = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           port_id;
    logic                 write_strobe, read_strobe;
    logic [7:0]           out_port;
    logic [7:0]           in_port;
    logic                 interrupt;
    logic                 interrupt_ack;
    logic [NUM_IN*8-1:0]  in_data;
    logic [NUM_IN-1:0]    in_rd_pulse;
    logic [NUM_OUT*8-1:0] out_data;
    logic [NUM_OUT-1:0]   out_wr_pulse;
    logic [NUM_IRQ-1:0]   irq_src;

    always #5 clk = ~clk;

    picoblaze_io_hub #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .NUM_IRQ(NUM_IRQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .in_data      (in_data),
        .in_rd_pulse  (in_rd_pulse),
        .out_data     (out_data),
        .out_wr_pulse (out_wr_pulse),
        .irq_src      (irq_src)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: register contents as plain integers, updated from each clock's sampled inputs
    logic [7:0]         m_out [NUM_OUT];
    logic [7:0]         m_in_port;
    logic [NUM_IN-1:0]  m_rd_pulse;
    logic [NUM_OUT-1:0] m_wr_pulse;
    int                 m_pend, m_mask, m_ovr, m_prev, m_phase;
    bit                 m_first;

    always @(posedge clk) begin : model
        int p, rd, edges, pend_n, ovr_n, rp, wp;
        bit act, clr;
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) m_out[k] <= 8'h00;
            m_in_port  <= 8'h00;
            m_rd_pulse <= '0;
            m_wr_pulse <= '0;
            m_pend     <= 0;
            m_mask     <= 0;
            m_ovr      <= 0;
            m_prev     <= 0;
            m_phase    <= PH_IDLE;
            m_first    <= 1'b1;
        end else begin
            p  = int'(port_id);
            rd = 0;
            if (p < NUM_IN) rd = int'(in_data[8*p +: 8]);
            else if (p >= 'h20 && p < 'h20 + NUM_OUT) rd = int'(m_out[p - 'h20]);
            else if (p == 'h10) rd = m_pend;
            else if (p == 'h11) rd = m_mask;
            else if (p == 'h13) rd = m_ovr;
            m_in_port <= rd[7:0];

            rp = (read_strobe && p < NUM_IN) ? (1 << p) : 0;
            wp = (write_strobe && p >= 'h20 && p < 'h20 + NUM_OUT) ? (1 << (p - 'h20)) : 0;
            m_rd_pulse <= rp[NUM_IN-1:0];
            m_wr_pulse <= wp[NUM_OUT-1:0];
            if (wp != 0) m_out[p - 'h20] <= out_port;

            edges  = m_first ? 0 : (int'(irq_src) & ~m_prev & ALL_IRQ);
            clr    = write_strobe && p == 'h12;
            pend_n = (clr ? (m_pend & ~int'(out_port)) : m_pend) | edges;
            ovr_n  = ((write_strobe && p == 'h13) ? 0 : m_ovr) | (edges & m_pend);
            if (write_strobe && p == 'h11) m_mask <= int'(out_port) & ALL_IRQ;
            act = (m_pend & m_mask) != 0;
            if (m_phase == PH_IDLE && act) m_phase <= PH_REQ;
            else if (m_phase == PH_REQ && interrupt_ack) m_phase <= PH_SERVICE;
            else if (m_phase == PH_REQ && !act) m_phase <= PH_IDLE;
            else if (m_phase == PH_SERVICE && clr) m_phase <= PH_IDLE;
            m_pend  <= pend_n & ALL_IRQ;
            m_ovr   <= ovr_n & ALL_IRQ;
            m_prev  <= int'(irq_src);
            m_first <= 1'b0;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        chk("cyc in_port", 32'(in_port), 32'(m_in_port));
        chk("cyc interrupt", 32'(interrupt), 32'(m_phase == PH_REQ));
        chk("cyc in_rd_pulse", 32'(in_rd_pulse), 32'(m_rd_pulse));
        chk("cyc out_wr_pulse", 32'(out_wr_pulse), 32'(m_wr_pulse));
        for (int k = 0; k < NUM_OUT; k++) chk("cyc out_data", 32'(out_data[8*k +: 8]), 32'(m_out[k]));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        port_id = a; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        d = in_port;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
    endtask

    logic [7:0] d;

    initial begin
        reset = 1'b1; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        out_port = 8'h00; interrupt_ack = 1'b0; irq_src = '0;
        in_data = 32'h44C3_2211;
        step(3);
        chk("reset in_port", 32'(in_port), 32'h0);
        chk("reset interrupt", 32'(interrupt), 32'h0);
        chk("reset out_data", out_data, 32'h0);
        reset = 1'b0;
        step(1);

        // output register write / readback, out-of-range write ignored
        wr(8'h21, 8'h5A);
        chk("wr21 out_data", out_data, 32'h0000_5A00);
        chk("wr21 pulse", 32'(out_wr_pulse), 32'b0010);
        step(1);
        chk("wr21 pulse gone", 32'(out_wr_pulse), 32'h0);
        rd(8'h21, d);
        chk("rd21", 32'(d), 32'h5A);
        wr(8'h24, 8'h33);
        chk("wr24 pulse", 32'(out_wr_pulse), 32'h0);
        chk("wr24 out_data", out_data, 32'h0000_5A00);

        // input ports and unmapped reads
        rd(8'h02, d);
        chk("rd02", 32'(d), 32'hC3);
        chk("rd02 pulse", 32'(in_rd_pulse), 32'b0100);
        rd(8'h07, d);
        chk("rd07", 32'(d), 32'h00);
        chk("rd07 pulse", 32'(in_rd_pulse), 32'h0);
        rd(8'h12, d);
        chk("rd clear reg", 32'(d), 32'h00);
        wr(8'h11, 8'hFF);
        rd(8'h11, d);
        chk("mask upper bits", 32'(d), 32'h0F);

        // single source request / ack / clear
        wr(8'h11, 8'h01);
        irq_src = 4'b0001;
        step(1);
        chk("irq not yet", 32'(interrupt), 32'h0);
        step(1);
        chk("irq raised", 32'(interrupt), 32'h1);
        rd(8'h10, d);
        chk("pending 01", 32'(d), 32'h01);
        ack();
        chk("irq after ack", 32'(interrupt), 32'h0);
        wr(8'h12, 8'h01);
        rd(8'h10, d);
        chk("pending cleared", 32'(d), 32'h00);
        step(3);
        chk("idle steady level", 32'(interrupt), 32'h0);
        irq_src = 4'b0000;
        step(1);

        // edges during SERVICE, partial clear re-requests
        wr(8'h11, 8'h03);
        irq_src = 4'b0001;
        step(2);
        chk("svc irq raised", 32'(interrupt), 32'h1);
        ack();
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b0011;
        step(2);
        chk("svc holds irq", 32'(interrupt), 32'h0);
        rd(8'h10, d);
        chk("svc pending 03", 32'(d), 32'h03);
        wr(8'h12, 8'h01);
        chk("svc exit low", 32'(interrupt), 32'h0);
        step(1);
        chk("svc re-request", 32'(interrupt), 32'h1);
        ack();
        wr(8'h12, 8'h02);
        step(1);
        chk("svc done", 32'(interrupt), 32'h0);
        rd(8'h13, d);
        chk("overrun bit0", 32'(d), 32'h01);
        wr(8'h13, 8'h00);
        rd(8'h13, d);
        chk("overrun cleared", 32'(d), 32'h00);
        irq_src = 4'b0000;
        wr(8'h11, 8'h00);

        // overrun and set-beats-clear on source 2
        irq_src = 4'b0100;
        step(2);
        rd(8'h10, d);
        chk("pending 04", 32'(d), 32'h04);
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b0100;
        step(2);
        rd(8'h13, d);
        chk("overrun 04", 32'(d), 32'h04);
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b0100;
        wr(8'h12, 8'h04);
        rd(8'h10, d);
        chk("set beats clear", 32'(d), 32'h04);
        wr(8'h12, 8'h04);
        rd(8'h10, d);
        chk("plain clear", 32'(d), 32'h00);
        wr(8'h13, 8'hFF);
        rd(8'h13, d);
        chk("overrun any write", 32'(d), 32'h00);
        irq_src = 4'b0000;

        // reset while requesting, source high across release
        wr(8'h11, 8'h01);
        irq_src = 4'b0001;
        step(2);
        chk("pre-reset irq", 32'(interrupt), 32'h1);
        reset = 1'b1; port_id = 8'h20; out_port = 8'h77; write_strobe = 1'b1; interrupt_ack = 1'b1;
        step(1);
        chk("rst irq", 32'(interrupt), 32'h0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst wr pulse", 32'(out_wr_pulse), 32'h0);
        write_strobe = 1'b0; interrupt_ack = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        rd(8'h11, d);
        chk("rst mask", 32'(d), 32'h00);
        wr(8'h11, 8'h01);
        step(3);
        chk("no edge at release", 32'(interrupt), 32'h0);
        rd(8'h10, d);
        chk("no pending at release", 32'(d), 32'h00);
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b0001;
        step(2);
        chk("edge after release", 32'(interrupt), 32'h1);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/picoblaze_io_hub.md
PICOBLAZE_IO_HUB -- requirements
Module: picoblaze_io_hub

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning number of 8-bit input ports (1..8).
REQ-002 SHALL have parameter NUM_OUT, default 4, meaning number of 8-bit output registers (1..8).
REQ-003 SHALL have parameter NUM_IRQ, default 4, meaning number of interrupt sources (1..8).
REQ-004 SHALL have ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- port_id  input  8  processor port address.
- write_strobe  input  1  processor write qualifier, one cycle.
- read_strobe  input  1  processor read qualifier, one cycle.
- out_port  input  8  processor write data.
- in_port  output  8  registered read data to processor.
- interrupt  output  1  interrupt request to processor.
- interrupt_ack  input  1  processor interrupt acknowledge, one-cycle pulse.
- in_data  input  NUM_IN*8  input port k on bits [8k+7:8k].
- in_rd_pulse  output  NUM_IN  one-cycle pulse when input port k is read.
- out_data  output  NUM_OUT*8  output register k on bits [8k+7:8k].
- out_wr_pulse  output  NUM_OUT  one-cycle pulse when output register k is written.
- irq_src  input  NUM_IRQ  level interrupt sources, synchronous to clk.

Function
REQ-005 SHALL fully decode port_id: 0x00+k input k (k<NUM_IN); 0x10 PENDING (R); 0x11 MASK (R/W); 0x12 CLEAR (W, write-1-to-clear PENDING); 0x13 OVERRUN (R; any write clears it); 0x20+k output register k (R/W, k<NUM_OUT).
REQ-006 SHALL register in_port from port_id every cycle regardless of read_strobe: value valid 1 cycle after port_id; unmapped or out-of-range addresses return 0x00.
REQ-007 SHALL pulse in_rd_pulse[k] in the cycle after read_strobe with port_id=0x00+k.
REQ-008 SHALL update output register k and pulse out_wr_pulse[k] in the cycle after write_strobe with port_id=0x20+k; other writes leave registers unchanged.
REQ-009 SHALL zero-extend PENDING, MASK and OVERRUN reads above bit NUM_IRQ-1; MASK writes SHALL ignore bits above NUM_IRQ-1.
REQ-010 SHALL register irq_src once and set PENDING[i] on each 0->1 transition (one cycle after the edge); a steady high level SHALL not re-set it.
REQ-011 SHALL set OVERRUN[i] when a rising edge on source i occurs while PENDING[i] is already 1.
REQ-012 SHALL give set priority over clear: an edge coinciding with a CLEAR write of the same bit leaves PENDING[i]=1.
REQ-013 SHALL implement interrupt FSM with states IDLE, REQ, SERVICE:
- IDLE -> REQ when (PENDING & MASK) != 0; interrupt=1 from the next cycle.
- REQ -> SERVICE on interrupt_ack; interrupt=0 the next cycle.
- REQ -> IDLE if (PENDING & MASK) becomes 0 before ack; interrupt drops.
- SERVICE -> IDLE on any CLEAR write; if (PENDING & MASK) is still nonzero, SHALL return to REQ the next cycle.
- interrupt=1 only in REQ.
REQ-014 SHALL ignore interrupt_ack outside REQ.
REQ-015 SHALL keep new edges arriving in SERVICE pending, with no interrupt until SERVICE exits.

Reset
REQ-016 SHALL on reset clear out_data, MASK, PENDING, OVERRUN and the irq_src register, and set in_port=0x00, interrupt=0, all pulses 0, FSM=IDLE.
REQ-017 SHALL treat reset mid-operation (any FSM state, coincident strobes or edges) as dominant; no register update or pulse occurs in a reset cycle.
REQ-018 SHALL not detect a rising edge on a source already high when reset releases.

Structure
REQ-019 SHALL take address constants (0x00, 0x10-0x13, 0x20) and the FSM state enum from shared package picoblaze_io_pkg.
REQ-020 SHALL put edge detect, PENDING/MASK/OVERRUN and the FSM in sub-module picoblaze_irq_ctrl; address decode and port registers stay in the top level.

Verification
REQ-021 Write 0x5A to 0x21 -> out_data[15:8]=0x5A, out_wr_pulse=4'b0010 for one cycle; read 0x21 -> in_port=0x5A.
REQ-022 in_data port 2 = 0xC3, read 0x02 -> in_port=0xC3 one cycle later, in_rd_pulse=4'b0100; read 0x07 -> 0x00.
REQ-023 MASK=0x01, irq_src[0] rising -> PENDING=0x01, interrupt=1; ack -> interrupt=0; write 0x01 to 0x12 -> PENDING=0x00, FSM IDLE.
REQ-024 MASK=0x03, edges on src0 and src1 in SERVICE, clear only bit0 -> interrupt reasserts for bit1 one cycle after exit.
REQ-025 Second src2 edge while PENDING[2]=1 -> OVERRUN=0x04; edge coincident with clear of bit2 -> PENDING[2] stays 1.
REQ-026 Assert reset in REQ with out_data nonzero -> interrupt=0, out_data=0, MASK=0 next cycle; src held high through release -> no PENDING.
